// File: rtl/bus_terminator.sv
// ============================================================================
// Module      : bus_terminator
// Description : 68EC020 bus-cycle terminator for fast RAM, IDE and autoconfig.
//               It issues a sized DSACK for each claimed cycle. When the macro
//               BUS_TIMEOUT_EN is defined, a watchdog adds a BERR termination.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_terminator #(
  parameter int IDE_WS  = 4,
  parameter int Z2_WS   = 2,
  parameter int TIMEOUT = 200
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RAM_ACCESS,
  input  logic       WAIT,
  input  logic       Z2_ACCESS,
  input  logic       IDE_ACCESS,
  output logic [1:0] DSACK,
  output logic       BERR,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAM_WAIT  = 3'd1,
    S_IDE_WAIT  = 3'd2,
    S_Z2_WAIT   = 3'd3,
    S_ACK       = 3'd4,
    S_BERR_HOLD = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       as20_d_q, as20_d_d;
  logic       armed_q, armed_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] dsack_q, dsack_d;
  logic       start;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;
  logic       berr_q, berr_d;
`else
  logic [7:0] w_unused_timeout;
  assign w_unused_timeout = 8'(TIMEOUT);
`endif

  // armed_q blocks a false start when reset is released in the middle of a cycle.
  assign start = armed_q & as20_d_q & ~AS20;

  always_comb begin
    state_d  = state_q;
    as20_d_d = AS20;
    armed_d  = armed_q | AS20;
    cnt_d    = cnt_q;
    dsack_d  = dsack_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!RAM_ACCESS) begin
            state_d = S_RAM_WAIT;
          end else if (!IDE_ACCESS) begin
            state_d = S_IDE_WAIT;
            cnt_d   = 4'(IDE_WS);
          end else if (!Z2_ACCESS) begin
            state_d = S_Z2_WAIT;
            cnt_d   = 4'(Z2_WS);
          end
        end
      end
      S_RAM_WAIT: begin
        if (AS20) begin
          state_d = S_IDLE;
          dsack_d = 2'b11;
        end else if (!WAIT) begin
          state_d = S_ACK;
          dsack_d = 2'b00;
        end
      end
      S_IDE_WAIT, S_Z2_WAIT: begin
        if (AS20) begin
          state_d = S_IDLE;
          dsack_d = 2'b11;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          dsack_d = (state_q == S_IDE_WAIT) ? 2'b01 : 2'b10;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK, S_BERR_HOLD: begin
        if (AS20) begin
          state_d = S_IDLE;
          dsack_d = 2'b11;
        end
      end
      default: begin
        state_d = S_IDLE;
        dsack_d = 2'b11;
      end
    endcase

`ifdef BUS_TIMEOUT_EN
    wdog_d = wdog_q;
    if (state_q == S_IDLE) begin
      wdog_d = 8'd0;
    end else if ((state_q == S_RAM_WAIT || state_q == S_IDE_WAIT || state_q == S_Z2_WAIT)
                 && state_d == state_q) begin
      // Only reached when neither termination nor abandonment happened this edge.
      wdog_d = wdog_q + 8'd1;
      if (wdog_q + 8'd1 == 8'(TIMEOUT)) begin
        state_d = S_BERR_HOLD;
        dsack_d = 2'b11;
        cnt_d   = 4'd0;
      end
    end
    berr_d = (state_d != S_BERR_HOLD);
`endif
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      as20_d_q <= 1'b1;
      armed_q  <= 1'b0;
      cnt_q    <= 4'd0;
      dsack_q  <= 2'b11;
`ifdef BUS_TIMEOUT_EN
      wdog_q   <= 8'd0;
      berr_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      as20_d_q <= as20_d_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      dsack_q  <= dsack_d;
`ifdef BUS_TIMEOUT_EN
      wdog_q   <= wdog_d;
      berr_q   <= berr_d;
`endif
    end
  end

  assign DSACK = dsack_q;
  assign BUSY  = (state_q != S_IDLE);
`ifdef BUS_TIMEOUT_EN
  assign BERR  = berr_q;
`else
  assign BERR  = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_terminator.sv
// ============================================================================
// Module      : tb_bus_terminator
// Description : Directed self-checking bench for bus_terminator; observes
//               {BUSY, BERR, DSACK} one time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_terminator;

  logic       clk;
  logic       rst;
  logic       as20;
  logic       ram_access;
  logic       wait_n;
  logic       z2_access;
  logic       ide_access;
  logic [1:0] dsack;
  logic       berr;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  // Expected codes for {BUSY, BERR, DSACK}
  localparam logic [3:0] C_IDLE = 4'b0111;
  localparam logic [3:0] C_BUSY = 4'b1111;
  localparam logic [3:0] C_A32  = 4'b1100;
  localparam logic [3:0] C_A16  = 4'b1101;
  localparam logic [3:0] C_A8   = 4'b1110;
  localparam logic [3:0] C_BERR = 4'b1011;

  bus_terminator #(
    .IDE_WS (4),
    .Z2_WS  (2),
    .TIMEOUT(200)
  ) dut (
    .CLKCPU    (clk),
    .RESET     (rst),
    .AS20      (as20),
    .RAM_ACCESS(ram_access),
    .WAIT      (wait_n),
    .Z2_ACCESS (z2_access),
    .IDE_ACCESS(ide_access),
    .DSACK     (dsack),
    .BERR      (berr),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {busy,berr,dsack}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic [3:0] exp);
    tick();
    check_val(tag, {busy, berr, dsack}, exp);
  endtask

  task automatic idle_inputs();
    as20       = 1'b1;
    ram_access = 1'b1;
    wait_n     = 1'b1;
    z2_access  = 1'b1;
    ide_access = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick_chk("reset", C_IDLE);
    rst = 1'b0;
    tick_chk("post_reset_idle", C_IDLE);

    // RAM cycle, WAIT asserted on the third edge after the start edge
    as20 = 1'b0; ram_access = 1'b0;
    tick_chk("ram_start", C_BUSY);
    ram_access = 1'b1;
    tick_chk("ram_wait1", C_BUSY);
    tick_chk("ram_wait2", C_BUSY);
    wait_n = 1'b0;
    tick_chk("ram_ack", C_A32);
    wait_n = 1'b1;
    tick_chk("ram_hold", C_A32);
    as20 = 1'b1;
    tick_chk("ram_release", C_IDLE);

    // IDE cycle: DSACK=01 on the 4th edge after start
    as20 = 1'b0; ide_access = 1'b0;
    tick_chk("ide_start", C_BUSY);
    for (int i = 1; i < 4; i++) tick_chk("ide_count", C_BUSY);
    tick_chk("ide_ack", C_A16);
    ide_access = 1'b1;
    as20 = 1'b1;
    tick_chk("ide_release", C_IDLE);

    // Back-to-back Z2 cycle: DSACK=10 on the 2nd edge after start
    as20 = 1'b0; z2_access = 1'b0;
    tick_chk("z2_start", C_BUSY);
    tick_chk("z2_count", C_BUSY);
    tick_chk("z2_ack", C_A8);
    z2_access = 1'b1;
    as20 = 1'b1;
    tick_chk("z2_release", C_IDLE);

    // RAM wins over IDE; no ack until WAIT
    as20 = 1'b0; ram_access = 1'b0; ide_access = 1'b0;
    tick_chk("prio_start", C_BUSY);
    for (int i = 0; i < 5; i++) tick_chk("prio_no_ide_ack", C_BUSY);
    wait_n = 1'b0;
    tick_chk("prio_ram_ack", C_A32);
    idle_inputs();
    tick_chk("prio_release", C_IDLE);

    // Abandoned RAM cycle: no DSACK pulse
    as20 = 1'b0; ram_access = 1'b0;
    tick_chk("abandon_start", C_BUSY);
    tick_chk("abandon_wait", C_BUSY);
    as20 = 1'b1;
    tick_chk("abandon_idle", C_IDLE);
    wait_n = 1'b0;
    tick_chk("abandon_no_ack", C_IDLE);
    idle_inputs();

    // Unclaimed cycle stays with the motherboard
    as20 = 1'b0;
    tick_chk("unclaimed_start", C_IDLE);
    tick_chk("unclaimed_hold", C_IDLE);
    as20 = 1'b1;
    tick_chk("unclaimed_end", C_IDLE);

    // Reset in IDE_WAIT, including the edge that would have terminated
    as20 = 1'b0; ide_access = 1'b0;
    tick_chk("rst_ide_start", C_BUSY);
    tick_chk("rst_ide_count1", C_BUSY);
    tick_chk("rst_ide_count2", C_BUSY);
    tick_chk("rst_ide_count3", C_BUSY);
    rst = 1'b1;
    tick_chk("rst_overrides_ack", C_IDLE);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick_chk("rst_no_false_start", C_IDLE);
    as20 = 1'b1;
    tick_chk("rst_rearm", C_IDLE);
    as20 = 1'b0;
    tick_chk("rst_restart", C_BUSY);
    for (int i = 1; i < 4; i++) tick_chk("rst_restart_count", C_BUSY);
    tick_chk("rst_restart_ack", C_A16);
    idle_inputs();
    tick_chk("rst_restart_release", C_IDLE);

    // RAM cycle with WAIT never asserted
    as20 = 1'b0; ram_access = 1'b0;
    tick_chk("wd_start", C_BUSY);
`ifdef BUS_TIMEOUT_EN
    for (int i = 1; i < 200; i++) tick();
    check_val("wd_before_limit", {busy, berr, dsack}, C_BUSY);
    tick_chk("wd_berr", C_BERR);
    tick_chk("wd_berr_hold", C_BERR);
    as20 = 1'b1;
    tick_chk("wd_release", C_IDLE);
`else
    for (int i = 0; i < 1000; i++) tick();
    check_val("no_wd_still_waiting", {busy, berr, dsack}, C_BUSY);
    as20 = 1'b1;
    tick_chk("no_wd_release", C_IDLE);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
